// File: rtl/nor_gate.sv
// Bitwise NOR leaf cell: combinational y plus registered y_q/out_valid.
// Define NOR_GATE_STATS_EN to compile in the saturating hi_count counter.

module nor_gate_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cap,
  output logic y,
  output logic y_q
);
  assign y = ~(a | b);

  always_ff @(posedge clk) begin
    if (!rst_n)   y_q <= 1'b0;
    else if (cap) y_q <= y;
  end
endmodule

module nor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             y_any,
`ifdef NOR_GATE_STATS_EN
  input  logic             count_clr,
  output logic [CNT_W-1:0] hi_count
`else
  input  logic             count_clr
`endif
);
  localparam int STAGES = 1;

  logic [STAGES:0] vld_pipe;

  genvar l;
  generate
    for (l = 0; l < WIDTH; l++) begin : g_lane
      nor_gate_lane u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a[l]),
        .b    (b[l]),
        .cap  (in_valid),
        .y    (y[l]),
        .y_q  (y_q[l])
      );
    end
  endgenerate

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign out_valid = vld_pipe[STAGES];
  assign y_any     = |y_q;

`ifdef NOR_GATE_STATS_EN
  // Clear beats increment; counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || count_clr)                   hi_count <= '0;
    else if (in_valid && (|y) && !(&hi_count)) hi_count <= hi_count + 1'b1;
  end
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
`endif

endmodule

// File: tb/tb_nor_gate.sv
// Self-checking bench for nor_gate: directed steps then random cycles vs a cycle model.
module tb_nor_gate;
  localparam int W  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  logic          rst_n, in_valid, count_clr;
  logic [W-1:0]  a, b, y, y_q;
  logic          out_valid, y_any;
  logic          a1, b1, y1, yq1, ov1, yany1;
`ifdef NOR_GATE_STATS_EN
  logic [CW-1:0] hi_count, hc1;
`endif

  nor_gate #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .y(y), .in_valid(in_valid),
    .y_q(y_q), .out_valid(out_valid), .y_any(y_any),
`ifdef NOR_GATE_STATS_EN
    .count_clr(count_clr), .hi_count(hi_count)
`else
    .count_clr(count_clr)
`endif
  );

  nor_gate #(.WIDTH(1), .CNT_W(CW)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .y(y1), .in_valid(1'b0),
    .y_q(yq1), .out_valid(ov1), .y_any(yany1),
`ifdef NOR_GATE_STATS_EN
    .count_clr(1'b0), .hi_count(hc1)
`else
    .count_clr(1'b0)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int m_yq, m_ov, m_cnt;

  function automatic int nor_ref(int x, int z);
    return (2**W - 1) - (x | z);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: drive, check y before edge, advance model, check registers after edge
  task automatic cycle(input int av, input int bv, input bit iv, input bit clr, input bit rn);
    int n;
    a = av[W-1:0]; b = bv[W-1:0]; in_valid = iv; count_clr = clr; rst_n = rn;
    #1;
    chk("y_comb", 32'(y), 32'(nor_ref(av, bv)));
    @(posedge clk);
    n = nor_ref(av, bv);
    if (!rn) begin
      m_yq = 0; m_ov = 0; m_cnt = 0;
    end else begin
      if (iv) m_yq = n;
      m_ov = iv;
      if (clr) m_cnt = 0;
      else if (iv && n != 0 && m_cnt < 2**CW - 1) m_cnt = m_cnt + 1;
    end
    @(negedge clk);
    chk("y_q", 32'(y_q), 32'(m_yq));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("y_any", 32'(y_any), 32'(m_yq != 0));
`ifdef NOR_GATE_STATS_EN
    chk("hi_count", 32'(hi_count), 32'(m_cnt));
`endif
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; count_clr = 1'b0;
    a = '0; b = '0; a1 = 1'b0; b1 = 1'b0;
    m_yq = 0; m_ov = 0; m_cnt = 0;

    // truth table, clock stopped
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #10;
      chk("tt_w1", 32'(y1), 32'(i == 0));
    end
    a = 4'b0101; b = 4'b0011;
    #10;
    chk("tt_w4", 32'(y), 32'h8);

    clk_en = 1'b1;
    @(negedge clk);

    // reset with a pending capture
    cycle(0, 0, 1'b1, 1'b0, 1'b0);
    cycle(0, 0, 1'b1, 1'b0, 1'b0);

    // capture latency, then out_valid drops and y_q holds
    cycle(4'b0101, 4'b0011, 1'b1, 1'b0, 1'b1);
    chk("cap_yq", 32'(y_q), 32'h8);
    cycle(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
    cycle(4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1);
    cycle(4'b0010, 4'b0100, 1'b0, 1'b0, 1'b1);
    chk("hold_yq", 32'(y_q), 32'h8);

    // counter from zero through saturation
    cycle(0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1'b1, 1'b0, 1'b1);
    cycle(4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
    cycle(0, 0, 1'b1, 1'b1, 1'b1);
    cycle(0, 0, 1'b1, 1'b0, 1'b1);

    // reset wins over simultaneous capture
    cycle(0, 0, 1'b1, 1'b0, 1'b0);

    // random
    for (int i = 0; i < 200; i++)
      cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
